conv_layer_engine: RTL and testbench

//  Parametrised, self-sequencing convolution layer for the CNN datapath; next generation of the go/full_done top-level flow.
//  On go, slides a KxK window over a CH-channel IMG_H x IMG_W image ("valid" padding, stride 1).

---
 rtl/cnn_pkg.sv | 40 ++++
 rtl/conv_addr_gen.sv | 99 +++++++++
 rtl/conv_layer_engine.sv | 125 ++++++++++++
 tb/tb_conv_layer_engine.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared definitions for the convolution layer engine.
//   - FSM state encoding (3-bit legacy-compatible constants)
//   - clog2 / counter-width helpers
//   - derived geometry formulas: OUT_W/OUT_H (out_dim), N (taps), P (pixels)
package cnn_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_LOAD  = 3'd1;
    localparam logic [2:0] S_DRAIN = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    // Width of a counter that runs 0..v-1; never narrower than one bit.
    function automatic int cnt_w(input int v);
        return (v <= 1) ? 1 : clog2(v);
    endfunction

    // "Valid" convolution output size along one axis, stride 1.
    function automatic int out_dim(input int img, input int k);
        return img - k + 1;
    endfunction

    // N: taps per output pixel.
    function automatic int taps(input int ch, input int k);
        return ch * k * k;
    endfunction

    // P: output pixels per layer.
    function automatic int pixels(input int w, input int h, input int k);
        return out_dim(w, k) * out_dim(h, k);
    endfunction

endpackage

// File: rtl/conv_addr_gen.sv
// Window / pixel sequencer for conv_layer_engine.
// Nested counters: kc (fastest), kr, c for taps; col (fastest), row for pixels.
// Ports:
//   clk_i, reset_i          clock, synchronous active-high reset
//   tap_adv_i               step to the next tap (wraps to 0 after the last tap)
//   pix_adv_i               step to the next output pixel (wraps after the last)
//   first_tap_o/last_tap_o  current tap is the first/last of the window
//   last_pixel_o            current pixel is the last of the layer
//   img_addr_o, wt_addr_o   raw read addresses for the current tap
//   out_addr_o              raw write address for the current pixel
module conv_addr_gen
    import cnn_pkg::*;
#(
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8,
    parameter int K      = 3,
    parameter int CH     = 1,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              tap_adv_i,
    input  logic              pix_adv_i,
    output logic              first_tap_o,
    output logic              last_tap_o,
    output logic              last_pixel_o,
    output logic [ADDR_W-1:0] img_addr_o,
    output logic [ADDR_W-1:0] wt_addr_o,
    output logic [ADDR_W-1:0] out_addr_o
);
    localparam int OUT_W = out_dim(IMG_W, K);
    localparam int OUT_H = out_dim(IMG_H, K);
    localparam int KW    = cnt_w(K);
    localparam int CW    = cnt_w(CH);
    localparam int XW    = cnt_w(OUT_W);
    localparam int YW    = cnt_w(OUT_H);

    logic [KW-1:0] kc_q, kc_d, kr_q, kr_d;
    logic [CW-1:0] c_q, c_d;
    logic [XW-1:0] col_q, col_d;
    logic [YW-1:0] row_q, row_d;

    logic kc_last, kr_last, c_last, col_last, row_last;

    assign kc_last  = (kc_q  == KW'(K - 1));
    assign kr_last  = (kr_q  == KW'(K - 1));
    assign c_last   = (c_q   == CW'(CH - 1));
    assign col_last = (col_q == XW'(OUT_W - 1));
    assign row_last = (row_q == YW'(OUT_H - 1));

    assign first_tap_o  = (kc_q == '0) && (kr_q == '0) && (c_q == '0);
    assign last_tap_o   = kc_last && kr_last && c_last;
    assign last_pixel_o = col_last && row_last;

    // Every counter wraps to zero after its last value, so a completed
    // layer leaves the generator ready for the next one without a clear.
    always_comb begin
        kc_d  = kc_q;
        kr_d  = kr_q;
        c_d   = c_q;
        col_d = col_q;
        row_d = row_q;
        if (tap_adv_i) begin
            kc_d = kc_last ? '0 : kc_q + 1'b1;
            if (kc_last) begin
                kr_d = kr_last ? '0 : kr_q + 1'b1;
                if (kr_last) c_d = c_last ? '0 : c_q + 1'b1;
            end
        end
        if (pix_adv_i) begin
            col_d = col_last ? '0 : col_q + 1'b1;
            if (col_last) row_d = row_last ? '0 : row_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            kc_q  <= '0;
            kr_q  <= '0;
            c_q   <= '0;
            col_q <= '0;
            row_q <= '0;
        end else begin
            kc_q  <= kc_d;
            kr_q  <= kr_d;
            c_q   <= c_d;
            col_q <= col_d;
            row_q <= row_d;
        end
    end

    assign img_addr_o = ADDR_W'(c_q) * ADDR_W'(IMG_W * IMG_H)
                      + (ADDR_W'(row_q) + ADDR_W'(kr_q)) * ADDR_W'(IMG_W)
                      + ADDR_W'(col_q) + ADDR_W'(kc_q);
    assign wt_addr_o  = ADDR_W'(c_q) * ADDR_W'(K * K)
                      + ADDR_W'(kr_q) * ADDR_W'(K) + ADDR_W'(kc_q);
    assign out_addr_o = ADDR_W'(row_q) * ADDR_W'(OUT_W) + ADDR_W'(col_q);

endmodule

// File: rtl/conv_layer_engine.sv
// Self-sequencing KxK, CH-channel "valid" convolution layer (stride 1).
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   go_i                  start request, sampled only in IDLE
//   busy_o                high in LOAD/DRAIN/WRITE
//   full_done_o           one-cycle pulse (DONE state) after the last write
//   img_rd_en_o           image/weight read strobe (LOAD)
//   img_addr_o/wt_addr_o  tap addresses, 0 when not reading
//   img_data_i/wt_data_i  signed read data, one cycle after the strobe
//   out_wr_en_o           output write strobe (WRITE)
//   out_addr_o            pixel address, 0 when not writing
//   out_data_o            registered result (ReLU optional), held between writes
module conv_layer_engine
    import cnn_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int IMG_W   = 8,
    parameter int IMG_H   = 8,
    parameter int K       = 3,
    parameter int CH      = 1,
    parameter int RELU_EN = 1,
    parameter int ADDR_W  = 16
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              go_i,
    output logic              busy_o,
    output logic              full_done_o,
    output logic              img_rd_en_o,
    output logic [ADDR_W-1:0] img_addr_o,
    input  logic [DATA_W-1:0] img_data_i,
    output logic [ADDR_W-1:0] wt_addr_o,
    input  logic [DATA_W-1:0] wt_data_i,
    output logic              out_wr_en_o,
    output logic [ADDR_W-1:0] out_addr_o,
    output logic [ACC_W-1:0]  out_data_o
);
    logic [2:0] state_q, state_d;
    logic       load, drain, write;
    logic       first_tap, last_tap, last_pixel;
    logic [ADDR_W-1:0] ag_img, ag_wt, ag_out;

    // Read-data pipeline tags: data arriving this cycle is valid / first tap.
    logic tap_vld_q, first_q;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    prod_ext, acc_q, acc_d, result;
    logic        [ACC_W-1:0]    out_data_q;

    assign load  = (state_q == S_LOAD);
    assign drain = (state_q == S_DRAIN);
    assign write = (state_q == S_WRITE);

    conv_addr_gen #(
        .IMG_W (IMG_W),
        .IMG_H (IMG_H),
        .K     (K),
        .CH    (CH),
        .ADDR_W(ADDR_W)
    ) u_addr (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .tap_adv_i   (load),
        .pix_adv_i   (write),
        .first_tap_o (first_tap),
        .last_tap_o  (last_tap),
        .last_pixel_o(last_pixel),
        .img_addr_o  (ag_img),
        .wt_addr_o   (ag_wt),
        .out_addr_o  (ag_out)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (go_i) state_d = S_LOAD;
            S_LOAD:  if (last_tap) state_d = S_DRAIN;
            S_DRAIN: state_d = S_WRITE;
            S_WRITE: state_d = last_pixel ? S_DONE : S_LOAD;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // MAC: the first tap of a window overwrites the accumulator, so no
    // clear cycle is needed between pixels. Sums wrap on overflow.
    assign prod     = $signed(img_data_i) * $signed(wt_data_i);
    assign prod_ext = ACC_W'(prod);

    always_comb begin
        acc_d = acc_q;
        if (tap_vld_q) acc_d = first_q ? prod_ext : acc_q + prod_ext;
    end

    // DRAIN receives the last product; the finished sum is captured into
    // out_data at the DRAIN->WRITE edge so it is stable during WRITE.
    assign result = ((RELU_EN != 0) && (acc_d < 0)) ? '0 : acc_d;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q    <= S_IDLE;
            tap_vld_q  <= 1'b0;
            first_q    <= 1'b0;
            acc_q      <= '0;
            out_data_q <= '0;
        end else begin
            state_q   <= state_d;
            tap_vld_q <= load;
            first_q   <= load && first_tap;
            acc_q     <= acc_d;
            if (drain) out_data_q <= result;
        end
    end

    assign busy_o      = load || drain || write;
    assign full_done_o = (state_q == S_DONE);
    assign img_rd_en_o = load;
    assign img_addr_o  = load ? ag_img : '0;
    assign wt_addr_o   = load ? ag_wt : '0;
    assign out_wr_en_o = write;
    assign out_addr_o  = write ? ag_out : '0;
    assign out_data_o  = out_data_q;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Bench for conv_layer_engine: three instances sharing one image and one
// weight memory image.
//   u0: 4x4, K=3, CH=1, RELU on   (N=9,  P=4)
//   u1: 4x4, K=3, CH=2, RELU off  (N=18, P=4)
//   u2: 3x3, K=3, CH=1, RELU off  (N=9,  P=1, window equals image)
// Expected outputs come from a direct sum over the window coordinates.
module tb_conv_layer_engine;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       reset;
    logic [2:0] go;
    logic [2:0] busy, done, rd, wr;
    logic [15:0] img_addr [3];
    logic [15:0] wt_addr  [3];
    logic [15:0] out_addr [3];
    logic [23:0] out_data [3];
    logic [7:0]  img_d    [3];
    logic [7:0]  wt_d     [3];

    logic signed [7:0] img_mem [256];
    logic signed [7:0] wt_mem  [256];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        conv_layer_engine #(
            .DATA_W (8),
            .ACC_W  (24),
            .IMG_W  ((g == 2) ? 3 : 4),
            .IMG_H  ((g == 2) ? 3 : 4),
            .K      (3),
            .CH     ((g == 1) ? 2 : 1),
            .RELU_EN((g == 0) ? 1 : 0),
            .ADDR_W (16)
        ) u_dut (
            .clk_i      (clk),
            .reset_i    (reset),
            .go_i       (go[g]),
            .busy_o     (busy[g]),
            .full_done_o(done[g]),
            .img_rd_en_o(rd[g]),
            .img_addr_o (img_addr[g]),
            .img_data_i (img_d[g]),
            .wt_addr_o  (wt_addr[g]),
            .wt_data_i  (wt_d[g]),
            .out_wr_en_o(wr[g]),
            .out_addr_o (out_addr[g]),
            .out_data_o (out_data[g])
        );
    end

    // Synchronous memories, 1-cycle latency; data is 0 unless read.
    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            img_d[i] <= rd[i] ? img_mem[img_addr[i][7:0]] : 8'h00;
            wt_d[i]  <= rd[i] ? wt_mem[wt_addr[i][7:0]] : 8'h00;
        end
    end

    // Capture every write and every read address, per instance.
    logic [15:0] cap_addr [3][1024];
    logic [23:0] cap_data [3][1024];
    logic [15:0] rd_img   [3][4096];
    logic [15:0] rd_wt    [3][4096];
    int cap_cnt [3] = '{0, 0, 0};
    int rd_cnt  [3] = '{0, 0, 0};

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (wr[i]) begin
                if (cap_cnt[i] < 1024) begin
                    cap_addr[i][cap_cnt[i]] = out_addr[i];
                    cap_data[i][cap_cnt[i]] = out_data[i];
                end
                cap_cnt[i]++;
            end
            if (rd[i]) begin
                if (rd_cnt[i] < 4096) begin
                    rd_img[i][rd_cnt[i]] = img_addr[i];
                    rd_wt[i][rd_cnt[i]]  = wt_addr[i];
                end
                rd_cnt[i]++;
            end
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: direct window sums in pixel order, plus the tap
    // address sequence implied by the memory layout.
    logic [23:0] exp_data [64];
    logic [15:0] exp_img  [256];
    logic [15:0] exp_wt   [256];

    task automatic build_model(input int W, input int H, input int K, input int CH, input bit relu);
        int n, pix, s, ia, wa;
        logic [23:0] v;
        n = 0;
        pix = 0;
        for (int r = 0; r <= H - K; r++)
            for (int col = 0; col <= W - K; col++) begin
                s = 0;
                for (int c = 0; c < CH; c++)
                    for (int kr = 0; kr < K; kr++)
                        for (int kc = 0; kc < K; kc++) begin
                            ia = c * W * H + (r + kr) * W + (col + kc);
                            wa = c * K * K + kr * K + kc;
                            exp_img[n] = 16'(ia);
                            exp_wt[n]  = 16'(wa);
                            n++;
                            s += int'(img_mem[ia]) * int'(wt_mem[wa]);
                        end
                v = s[23:0];
                if (relu && v[23]) v = 24'd0;
                exp_data[pix] = v;
                pix++;
            end
    endtask

    task automatic chk_zero(input int id, input string tag);
        check({tag, "_busy"},  32'(busy[id]), 0);
        check({tag, "_done"},  32'(done[id]), 0);
        check({tag, "_rd"},    32'(rd[id]), 0);
        check({tag, "_wr"},    32'(wr[id]), 0);
        check({tag, "_iaddr"}, 32'(img_addr[id]), 0);
        check({tag, "_waddr"}, 32'(wt_addr[id]), 0);
        check({tag, "_oaddr"}, 32'(out_addr[id]), 0);
        check({tag, "_odata"}, 32'(out_data[id]), 0);
    endtask

    int hold_cb, hold_rb;

    // One layer pass on instance id. started: go was already accepted and
    // we sit on the negedge after that edge. hold: leave go high and verify
    // the automatic restart. poke: pulse go mid-run (must be ignored).
    task automatic run(input int id, input int W, input int H, input int K, input int CH,
                       input bit relu, input bit poke, input bit hold, input bit started);
        int n, p, start, cb, rb;
        bit seen;
        n = CH * K * K;
        p = (W - K + 1) * (H - K + 1);
        build_model(W, H, K, CH, relu);
        if (!started) begin
            @(negedge clk);
            cb = cap_cnt[id];
            rb = rd_cnt[id];
            go[id] = 1'b1;
            @(posedge clk);
            @(negedge clk);
        end else begin
            cb = hold_cb;
            rb = hold_rb;
        end
        if (!hold) go[id] = 1'b0;
        start = cyc;
        check("busy_after_go", 32'(busy[id]), 1);
        seen = 1'b0;
        for (int t = 0; t < p * (n + 2) + 16 && !seen; t++) begin
            if (done[id]) seen = 1'b1;
            else begin
                check("strobe_excl", 32'(rd[id] & wr[id]), 0);
                if (!rd[id]) check("rd_addr_idle", {img_addr[id], wt_addr[id]}, 0);
                if (!wr[id]) check("out_addr_idle", 32'(out_addr[id]), 0);
                if (poke && t == 4) go[id] = 1'b1;
                if (poke && t == 5) go[id] = 1'b0;
                @(negedge clk);
            end
        end
        check("done_seen", 32'(seen), 1);
        check("done_latency", 32'(cyc - start), 32'(p * (n + 2)));
        check("busy_in_done", 32'(busy[id]), 0);
        @(negedge clk);
        check("done_pulse", 32'(done[id]), 0);
        check("idle_busy", 32'(busy[id]), 0);
        check("write_count", 32'(cap_cnt[id] - cb), 32'(p));
        for (int k = 0; k < p && cb + k < 1024; k++) begin
            check("out_addr", 32'(cap_addr[id][cb + k]), 32'(k));
            check("out_data", 32'(cap_data[id][cb + k]), 32'(exp_data[k]));
        end
        check("read_count", 32'(rd_cnt[id] - rb), 32'(p * n));
        for (int k = 0; k < p * n && rb + k < 4096; k++) begin
            check("img_addr", 32'(rd_img[id][rb + k]), 32'(exp_img[k]));
            check("wt_addr",  32'(rd_wt[id][rb + k]),  32'(exp_wt[k]));
        end
        if (hold) begin
            hold_cb = cap_cnt[id];
            hold_rb = rd_cnt[id];
            @(negedge clk);
            check("restart_busy", 32'(busy[id]), 1);
            check("restart_rd", 32'(rd[id]), 1);
        end
    endtask

    task automatic chk_last(input int id, input int p, input int k, input logic [23:0] v);
        check("directed_out", 32'(cap_data[id][cap_cnt[id] - p + k]), 32'(v));
    endtask

    task automatic fill(input int pix_mode, input int wt_mode);
        for (int j = 0; j < 256; j++) begin
            case (pix_mode)
                0: img_mem[j] = 8'sd1;
                1: img_mem[j] = 8'(j);
                2: img_mem[j] = (j < 16) ? 8'sd1 : 8'sd2;
                default: img_mem[j] = 8'($urandom);
            endcase
            case (wt_mode)
                0: wt_mem[j] = 8'sd1;
                1: wt_mem[j] = -8'sd1;
                default: wt_mem[j] = 8'($urandom);
            endcase
        end
    endtask

    int base;

    initial begin
        reset = 1'b1;
        go    = 3'b000;
        fill(0, 0);
        repeat (3) @(negedge clk);
        chk_zero(0, "rst0");
        chk_zero(1, "rst1");
        chk_zero(2, "rst2");
        reset = 1'b0;

        // All ones: 9 per pixel, 44-cycle layer.
        run(0, 4, 4, 3, 1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) chk_last(0, 4, k, 24'd9);

        // Ramp image.
        fill(1, 0);
        run(0, 4, 4, 3, 1, 1, 0, 0, 0);
        chk_last(0, 4, 0, 24'd45);
        chk_last(0, 4, 1, 24'd54);
        chk_last(0, 4, 2, 24'd81);
        chk_last(0, 4, 3, 24'd90);

        // Negative sums: clamped with ReLU, raw without.
        fill(0, 1);
        run(0, 4, 4, 3, 1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) chk_last(0, 4, k, 24'd0);
        run(2, 3, 3, 3, 1, 0, 0, 0, 0);
        chk_last(2, 1, 0, 24'hFFFFF7);

        // Two channels.
        fill(2, 0);
        run(1, 4, 4, 3, 2, 0, 0, 0, 0);
        for (int k = 0; k < 4; k++) chk_last(1, 4, k, 24'd27);
        check("ch1_first_img", 32'(rd_img[1][rd_cnt[1] - 72 + 9]), 16);
        check("last_wt", 32'(rd_wt[1][rd_cnt[1] - 72 + 17]), 17);

        // Reset in the middle of the second pixel's LOAD.
        fill(0, 0);
        @(negedge clk);
        base = cap_cnt[0];
        go[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        go[0] = 1'b0;
        repeat (13) @(negedge clk);
        check("pre_reset_writes", 32'(cap_cnt[0] - base), 1);
        check("pre_reset_loading", 32'(rd[0]), 1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk_zero(0, "midrst");
        repeat (40) @(negedge clk);
        check("post_reset_writes", 32'(cap_cnt[0] - base), 1);
        check("post_reset_busy", 32'(busy[0]), 0);
        run(0, 4, 4, 3, 1, 1, 0, 0, 0);
        for (int k = 0; k < 4; k++) chk_last(0, 4, k, 24'd9);

        // go pulsed while busy, then go held across DONE.
        fill(3, 3);
        run(0, 4, 4, 3, 1, 1, 1, 0, 0);
        run(0, 4, 4, 3, 1, 1, 0, 1, 0);
        run(0, 4, 4, 3, 1, 1, 0, 0, 1);

        // Random data on every configuration.
        for (int it = 0; it < 3; it++) begin
            fill(3, 3);
            run(0, 4, 4, 3, 1, 1, 0, 0, 0);
            run(1, 4, 4, 3, 2, 0, 0, 0, 0);
            run(2, 3, 3, 3, 1, 0, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
